// File: rtl/au_pkg.sv
// au_pkg -- shared definitions for the digit-serial sign-conditioning unit.
//   * operation encodings for the 2-bit op input
//   * FSM state encoding
//   * constant helpers for digit count and counter width
//   * the invert decision shared by every operation
package au_pkg;

  localparam logic [1:0] AU_OP_PASS = 2'b00;
  localparam logic [1:0] AU_OP_NEG  = 2'b01;
  localparam logic [1:0] AU_OP_ABS  = 2'b10;
  localparam logic [1:0] AU_OP_NABS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } au_state_e;

  // Number of DIGIT-wide slices needed to cover WIDTH bits.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One's-complement-and-increment is needed when the result must have the
  // opposite sign of the operand: always for negate, for abs when the operand
  // is negative, for -|a| when it is non-negative.
  function automatic logic inv_flag(input logic [1:0] op, input logic sign);
    logic inv;
    case (op)
      AU_OP_PASS: inv = 1'b0;
      AU_OP_NEG:  inv = 1'b1;
      AU_OP_ABS:  inv = sign;
      AU_OP_NABS: inv = ~sign;
      default:    inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/au_neg_dig.sv
// au_neg_dig -- one DIGIT-bit slice of the conditional complementer.
// Computes {cout, sum} = (d XOR {DIGIT{inv}}) + cin.
// Ports:
//   d    [DIGIT-1:0]  operand digit
//   inv               invert this digit before adding
//   cin               carry in from the previous (less significant) digit
//   sum  [DIGIT-1:0]  result digit
//   cout              carry out to the next digit
module au_neg_dig #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] d,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
  end

endmodule

// File: rtl/au_neg_seq.sv
// au_neg_seq -- digit-serial pass / negate / abs / -abs unit.
// The operand is captured on an accepted start and processed DIGIT bits per
// cycle, LSB first, through a single au_neg_dig slice with a registered carry.
// The result is published on z (with ovf) only when the last digit is done.
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous reset, active high
//   start               request, accepted in IDLE or DONE
//   a     [WIDTH-1:0]   operand, sampled on accepted start
//   op    [1:0]         00 pass, 01 negate, 10 abs, 11 -|a|
//   busy                operation in progress
//   done                one-cycle pulse, z/ovf just updated
//   z     [WIDTH-1:0]   result, held until the next operation completes
//   ovf                 signed overflow (negate/abs of the most-negative value)
module au_neg_seq
  import au_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             ovf
);

  localparam int NDIG = ceil_div(WIDTH, DIGIT);
  // Internal registers are padded to whole digits; the padding bits of the
  // operand are zero and the padding bits of the result never reach z.
  localparam int PW   = NDIG * DIGIT;
  localparam int CW   = cnt_width(NDIG);

  localparam logic [CW-1:0]    LAST_DIG = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] ONE      = 1;
  localparam logic [WIDTH-1:0] MOST_NEG = ONE << (WIDTH - 1);

  au_state_e state, state_next;

  logic [PW-1:0]    opnd;      // remaining operand digits, shifted right
  logic [PW-1:0]    res;       // result digits, shifted in from the top
  logic [PW-1:0]    res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             inv_r;
  logic             ovf_r;     // overflow decided at accept, shown at done
  logic             accept;
  logic             inv_new;
  logic             last_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;

  assign inv_new  = inv_flag(op, a[WIDTH-1]);
  assign last_dig = (cnt == LAST_DIG);

  au_neg_dig #(
    .DIGIT (DIGIT)
  ) u_dig (
    .d    (opnd[DIGIT-1:0]),
    .inv  (inv_r),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // After NDIG shifts the first digit processed sits at bit 0.
  assign res_next = (res >> DIGIT) | (PW'(dig_sum) << (PW - DIGIT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_dig) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      inv_r <= 1'b0;
      ovf_r <= 1'b0;
      z     <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opnd  <= PW'(a);
      res   <= '0;
      cnt   <= '0;
      carry <= inv_new;
      inv_r <= inv_new;
      ovf_r <= inv_new & (a == MOST_NEG);
    end else if (state == ST_RUN) begin
      opnd  <= opnd >> DIGIT;
      res   <= res_next;
      carry <= dig_cout;
      if (last_dig) begin
        cnt <= '0;
        // Publish only the complete result, so z never shows partial digits.
        z   <= res_next[WIDTH-1:0];
        ovf <= ovf_r;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_au_neg_seq.sv
// tb_au_neg_seq -- directed bench for au_neg_seq across several WIDTH/DIGIT
// pairs. All instances share the input stimulus; each has its own outputs.
module tb_au_neg_seq;
  import au_pkg::*;

  localparam int N = 9;

  function automatic int w_of(input int i);
    case (i)
      0: return 16; 1: return 10; 2: return 16; 3: return 16; 4: return 16;
      5: return 7;  6: return 7;  7: return 7;  default: return 1;
    endcase
  endfunction

  function automatic int d_of(input int i);
    case (i)
      0: return 4; 1: return 4; 2: return 1; 3: return 3; 4: return 16;
      5: return 1; 6: return 3; 7: return 7; default: return 1;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [1:0]  op = '0;

  wire [N-1:0]       busy_v;
  wire [N-1:0]       done_v;
  wire [N-1:0]       ovf_v;
  wire [N-1:0][15:0] z_v;

  int errors = 0;
  int checks = 0;

  int          cap_lat   [N];
  int          cap_busy  [N];
  int          cap_pulse [N];
  logic [15:0] cap_z     [N];
  logic        cap_ovf   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    logic [W-1:0] zl;
    au_neg_seq #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a[W-1:0]),
      .op    (op),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .z     (zl),
      .ovf   (ovf_v[g])
    );
    assign z_v[g] = 16'(zl);
  end

  // Reference result computed as signed integer arithmetic on the operand.
  function automatic logic [15:0] ref_z(input int w, input logic [1:0] o,
                                        input logic [15:0] v);
    longint m, x, r;
    m = (longint'(1) << w) - 1;
    x = longint'(v) & m;
    if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    case (o)
      2'b00:   r = x;
      2'b01:   r = -x;
      2'b10:   r = (x < 0) ? -x : x;
      default: r = (x < 0) ? x : -x;
    endcase
    return 16'(r & m);
  endfunction

  function automatic logic ref_ovf(input int w, input logic [1:0] o,
                                   input logic [15:0] v);
    longint m, x;
    m = (longint'(1) << w) - 1;
    x = longint'(v) & m;
    return ((o == 2'b01) || (o == 2'b10)) && (x == (longint'(1) << (w - 1)));
  endfunction

  // Returns at a falling edge with every instance idle.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_v != '0 || done_v != '0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_v != '0 || done_v != '0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b done=%b still active after 40 cycles",
               busy_v, done_v);
    end
  endtask

  // Issue one operation, watch 24 cycles, and check every instance against
  // the reference model, the expected latency and a single done pulse.
  task automatic do_op(input logic [1:0] o, input logic [15:0] v);
    int ndig;
    wait_idle();
    start = 1'b1; op = o; a = v;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~v;   // must be ignored while busy
    for (int i = 0; i < N; i++) begin
      cap_lat[i] = -1; cap_busy[i] = 0; cap_pulse[i] = 0;
      cap_z[i] = 'x;   cap_ovf[i] = 1'bx;
    end
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N; i++) begin
        if (busy_v[i]) cap_busy[i]++;
        if (done_v[i]) begin
          cap_pulse[i]++;
          if (cap_lat[i] < 0) begin
            cap_lat[i] = k; cap_z[i] = z_v[i]; cap_ovf[i] = ovf_v[i];
          end
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      ndig = (w_of(i) + d_of(i) - 1) / d_of(i);
      checks += 5;
      if (cap_z[i] !== ref_z(w_of(i), o, v)) begin
        errors++;
        $display("FAIL z[%0d] op=%b a=%h: got %h want %h", i, o, v, cap_z[i],
                 ref_z(w_of(i), o, v));
      end
      if (cap_ovf[i] !== ref_ovf(w_of(i), o, v)) begin
        errors++;
        $display("FAIL ovf[%0d] op=%b a=%h: got %b want %b", i, o, v,
                 cap_ovf[i], ref_ovf(w_of(i), o, v));
      end
      if (cap_lat[i] != ndig) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, cap_lat[i], ndig);
      end
      if (cap_busy[i] != ndig) begin
        errors++;
        $display("FAIL busy_cycles[%0d]: got %0d want %0d", i, cap_busy[i], ndig);
      end
      if (cap_pulse[i] != 1) begin
        errors++;
        $display("FAIL done_pulses[%0d]: got %0d want 1", i, cap_pulse[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (busy_v !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_v); end
    if (done_v !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done_v); end
    if (ovf_v  !== '0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_v); end
    if (z_v    !== '0) begin errors++; $display("FAIL reset_z: got %h want 0", z_v); end
    rst = 1'b0;
  endtask

  task automatic test_negate();
    do_op(AU_OP_NEG, 16'h0001);
    checks += 5;
    if (cap_z[0] !== 16'hFFFF) begin errors++; $display("FAIL neg1_z16: got %h want FFFF", cap_z[0]); end
    if (cap_ovf[0] !== 1'b0)   begin errors++; $display("FAIL neg1_ovf16: got %b want 0", cap_ovf[0]); end
    if (cap_z[1] !== 16'h03FF) begin errors++; $display("FAIL neg1_z10: got %h want 03FF", cap_z[1]); end
    if (cap_busy[1] != 3)      begin errors++; $display("FAIL neg1_busy10: got %0d want 3", cap_busy[1]); end
    if (cap_z[8] !== 16'h0001 || cap_ovf[8] !== 1'b1) begin
      errors++; $display("FAIL neg1_w1: got z=%h ovf=%b want 1/1", cap_z[8], cap_ovf[8]);
    end
    do_op(AU_OP_NEG, 16'h8000);
    checks += 2;
    if (cap_z[0] !== 16'h8000) begin errors++; $display("FAIL negmin_z: got %h want 8000", cap_z[0]); end
    if (cap_ovf[0] !== 1'b1)   begin errors++; $display("FAIL negmin_ovf: got %b want 1", cap_ovf[0]); end
  endtask

  task automatic test_abs_nabs_pass();
    do_op(AU_OP_ABS, 16'hFFFB);
    checks++;
    if (cap_z[0] !== 16'h0005) begin errors++; $display("FAIL abs_z: got %h want 0005", cap_z[0]); end
    do_op(AU_OP_NABS, 16'h0005);
    checks++;
    if (cap_z[0] !== 16'hFFFB) begin errors++; $display("FAIL nabs_z: got %h want FFFB", cap_z[0]); end
    do_op(AU_OP_PASS, 16'h1234);
    checks += 2;
    if (cap_z[0] !== 16'h1234) begin errors++; $display("FAIL pass_z: got %h want 1234", cap_z[0]); end
    if (cap_ovf[0] !== 1'b0)   begin errors++; $display("FAIL pass_ovf: got %b want 0", cap_ovf[0]); end
    do_op(AU_OP_ABS, 16'h8000);
    checks += 2;
    if (cap_z[0] !== 16'h8000) begin errors++; $display("FAIL absmin_z: got %h want 8000", cap_z[0]); end
    if (cap_ovf[0] !== 1'b1)   begin errors++; $display("FAIL absmin_ovf: got %b want 1", cap_ovf[0]); end
    do_op(AU_OP_NABS, 16'h0000);
    checks += 2;
    if (cap_z[0] !== 16'h0000) begin errors++; $display("FAIL nabs0_z16: got %h want 0000", cap_z[0]); end
    if (cap_z[8] !== 16'h0000) begin errors++; $display("FAIL nabs0_w1: got %h want 0000", cap_z[8]); end
  endtask

  task automatic test_partial_digit();
    do_op(AU_OP_ABS, 16'h0200);
    checks += 3;
    if (cap_z[1] !== 16'h0200) begin errors++; $display("FAIL part_abs_z10: got %h want 0200", cap_z[1]); end
    if (cap_ovf[1] !== 1'b1)   begin errors++; $display("FAIL part_abs_ovf10: got %b want 1", cap_ovf[1]); end
    if (cap_lat[1] != 3)       begin errors++; $display("FAIL part_lat10: got %0d want 3", cap_lat[1]); end
  endtask

  task automatic test_start_while_busy();
    int lat, pulses;
    logic [15:0] zc;
    wait_idle();
    start = 1'b1; op = AU_OP_NEG; a = 16'h0001;
    @(negedge clk); start = 1'b0;        // first RUN cycle
    @(negedge clk);                      // second RUN cycle
    start = 1'b1; op = AU_OP_PASS; a = 16'h00FF;
    @(negedge clk); start = 1'b0;
    lat = -1; pulses = 0; zc = 'x;
    for (int k = 2; k < 16; k++) begin
      if (done_v[0]) begin
        pulses++;
        if (lat < 0) begin lat = k; zc = z_v[0]; end
      end
      @(negedge clk);
    end
    checks += 3;
    if (lat != 4)       begin errors++; $display("FAIL busy_start_lat: got %0d want 4", lat); end
    if (pulses != 1)    begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    if (zc !== 16'hFFFF) begin errors++; $display("FAIL busy_start_z: got %h want FFFF", zc); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [15:0] z_first, z_mid, z_second;
    wait_idle();
    start = 1'b1; op = AU_OP_NEG; a = 16'h0003;
    @(negedge clk); start = 1'b0; a = 16'hAAAA;
    first = -1; second = -1; z_first = 'x; z_mid = 'x; z_second = 'x;
    for (int k = 0; k < 24; k++) begin
      if (first >= 0 && k == first + 2) z_mid = z_v[0];
      if (done_v[0]) begin
        if (first < 0) begin
          first = k; z_first = z_v[0];
          start = 1'b1; op = AU_OP_PASS; a = 16'h5A5A;
        end else if (second < 0) begin
          second = k; z_second = z_v[0];
        end
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks += 5;
    if (first != 4)             begin errors++; $display("FAIL b2b_first: got %0d want 4", first); end
    if (second - first != 5)    begin errors++; $display("FAIL b2b_gap: got %0d want 5", second - first); end
    if (z_first !== 16'hFFFD)   begin errors++; $display("FAIL b2b_z1: got %h want FFFD", z_first); end
    if (z_mid !== 16'hFFFD)     begin errors++; $display("FAIL b2b_z_hold: got %h want FFFD", z_mid); end
    if (z_second !== 16'h5A5A)  begin errors++; $display("FAIL b2b_z2: got %h want 5A5A", z_second); end
  endtask

  task automatic test_abort();
    int seen;
    do_op(AU_OP_NEG, 16'h8000);          // leaves z=8000, ovf=1 on instance 0
    wait_idle();
    start = 1'b1; op = AU_OP_NEG; a = 16'h1234;
    @(negedge clk); start = 1'b0;        // first RUN cycle
    @(negedge clk);                      // second RUN cycle
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks += 5;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_v[0]); end
    if (done_v[0] !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done_v[0]); end
    if (z_v[0] !== 16'h0)   begin errors++; $display("FAIL abort_z: got %h want 0000", z_v[0]); end
    if (ovf_v[0] !== 1'b0)  begin errors++; $display("FAIL abort_ovf: got %b want 0", ovf_v[0]); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v != '0) seen++;
    end
    if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    do_op(AU_OP_NEG, 16'h1234);
    checks++;
    if (cap_z[0] !== 16'hEDCC) begin errors++; $display("FAIL after_abort_z: got %h want EDCC", cap_z[0]); end
  endtask

  task automatic test_sweep();
    logic [15:0] edge_v [6];
    edge_v = '{16'h0000, 16'hFFFF, 16'h0040, 16'h8000, 16'h7FFF, 16'h0001};
    for (int i = 0; i < 6; i++) do_op(2'(i % 4), edge_v[i]);
    for (int i = 0; i < 16; i++) do_op(2'($urandom_range(0, 3)), 16'($urandom));
  endtask

  initial begin
    test_reset();
    test_negate();
    test_abs_nabs_pass();
    test_partial_digit();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
